ifetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and replaces the single-cycle instruction ROM path of the IF stage. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned instructions go into a DEPTH-entry FIFO, and the FIFO head is presented to IF/ID. The queue honours the pipeline stall enable (IF_EN from the load-use detector) and flushes on a taken branch or jump redirect from the MEM stage.

---
 rtl/ifetch_queue.sv | 118 +++++++++++
 tb/tb_ifetch_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns fetch PC, reads imem over req/ack, buffers {PC, Inst} in a FIFO for IF/ID.
// Latency: first request one cycle after reset; Ack on cycle t makes the word visible at the head on t+1.
// Backpressure: EN=0 holds the head; no request is issued unless the returned word is guaranteed a free slot.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clr,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    input  logic        EN,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Targ,
    output logic [31:0] IFout_PC,
    output logic [31:0] IFout_PC4,
    output logic [31:0] IFout_Inst,
    output logic        IFout_Valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d, addr_q, addr_d, fpc_plus4;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          enq, deq;

    always_comb begin
        deq        = EN && (count != '0) && !Redirect;
        enq        = (state_q == WAIT) && IMem_Ack && !Redirect;
        count_next = count + CW'(enq) - CW'(deq);
        fpc_plus4  = fpc_q + 32'd4;
        state_d    = state_q;
        fpc_d      = fpc_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (Redirect) begin
                    fpc_d   = Redirect_Targ;
                    addr_d  = Redirect_Targ;
                    state_d = WAIT;
                end else if (count_next < FULL) begin
                    addr_d  = fpc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Redirect) begin
                    fpc_d = Redirect_Targ;
                    // Without an Ack the old request is still in flight; its address must stay put.
                    if (IMem_Ack) addr_d  = Redirect_Targ;
                    else          state_d = DROP;
                end else if (IMem_Ack) begin
                    fpc_d = fpc_plus4;
                    if (count_next < FULL) addr_d  = fpc_plus4;
                    else                   state_d = IDLE;
                end
            end
            DROP: begin
                if (Redirect) fpc_d = Redirect_Targ;
                if (IMem_Ack) begin
                    addr_d  = Redirect ? Redirect_Targ : fpc_q;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            if (Redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PW'(1);
                if (deq) rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge Clk) begin
        if (!Clr && enq) begin
            pc_mem[wr_ptr]   <= addr_q;
            inst_mem[wr_ptr] <= IMem_Data;
        end
    end

    assign IMem_Req    = (state_q != IDLE);
    assign IMem_Addr   = addr_q;
    assign IFout_Valid = (count != '0);
    assign IFout_PC    = IFout_Valid ? pc_mem[rd_ptr] : 32'h0;
    assign IFout_PC4   = IFout_Valid ? pc_mem[rd_ptr] + 32'd4 : 32'h0;
    assign IFout_Inst  = IFout_Valid ? inst_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a vector table for the basic flow, then hand sequences for streaming, fill, redirect and reset.
module tb_ifetch_queue;

    logic        Clk = 1'b0;
    logic        Clr, IMem_Req, IMem_Ack, EN, Redirect, IFout_Valid;
    logic [31:0] IMem_Addr, IMem_Data, Redirect_Targ, IFout_PC, IFout_PC4, IFout_Inst;
    int          checks = 0;
    int          failures = 0;

    always #5 Clk = ~Clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .Clk(Clk), .Clr(Clr), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .EN(EN), .Redirect(Redirect),
        .Redirect_Targ(Redirect_Targ), .IFout_PC(IFout_PC), .IFout_PC4(IFout_PC4),
        .IFout_Inst(IFout_Inst), .IFout_Valid(IFout_Valid)
    );

    typedef struct {
        logic        clr, en, ack, redir;
        logic [31:0] data, targ;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t tbl [17];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
        chk({nm, ".req"},   {31'b0, IMem_Req},    {31'b0, e_req});
        chk({nm, ".addr"},  IMem_Addr,            e_addr);
        chk({nm, ".valid"}, {31'b0, IFout_Valid}, {31'b0, e_valid});
        chk({nm, ".pc"},    IFout_PC,             e_pc);
        chk({nm, ".pc4"},   IFout_PC4,            e_valid ? e_pc + 32'd4 : 32'h0);
        chk({nm, ".inst"},  IFout_Inst,           e_inst);
    endtask

    task automatic do_reset();
        Clr = 1'b1; EN = 1'b0; IMem_Ack = 1'b0; IMem_Data = '0; Redirect = 1'b0; Redirect_Targ = '0;
        tick();
        Clr = 1'b0;
    endtask

    // Zero-wait memory: Ack mirrors Req, memory word equals its address.
    task automatic zw_tick();
        IMem_Ack  = IMem_Req;
        IMem_Data = IMem_Addr;
        tick();
    endtask

    initial begin
        //          clr  en   ack  rdr  data          targ          req  addr          vld  pc            inst
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,32'h1000_0000,32'h0,        1'b1,32'h4,        1'b1,32'h0,        32'h1000_0000};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h1000_0004,32'h0,        1'b1,32'h8,        1'b1,32'h4,        32'h1000_0004};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,32'h1000_0008,32'h0,        1'b1,32'hC,        1'b1,32'h8,        32'h1000_0008};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'hC,        1'b0,32'h0,        32'h0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,32'h1000_000C,32'h0,        1'b1,32'h10,       1'b1,32'hC,        32'h1000_000C};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h10,       1'b1,32'hC,        32'h1000_000C};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,32'h0,        32'h200,      1'b1,32'h10,       1'b0,32'h0,        32'h0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,32'hDEAD_BEEF,32'h0,        1'b1,32'h200,      1'b0,32'h0,        32'h0};
        tbl[10] = '{1'b0,1'b1,1'b1,1'b0,32'h2000_0200,32'h0,        1'b1,32'h204,      1'b1,32'h200,      32'h2000_0200};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,32'h0BAD_0BAD,32'h300,      1'b1,32'h300,      1'b0,32'h0,        32'h0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h300,      1'b0,32'h0,        32'h0};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b0,32'h3000_0300,32'h0,        1'b1,32'h304,      1'b1,32'h300,      32'h3000_0300};
        tbl[14] = '{1'b0,1'b1,1'b1,1'b1,32'h0BAD_0BAD,32'hFFFF_FFFC,1'b1,32'hFFFF_FFFC,1'b0,32'h0,        32'h0};
        tbl[15] = '{1'b0,1'b0,1'b1,1'b0,32'h77,       32'h0,        1'b1,32'h0,        1'b1,32'hFFFF_FFFC,32'h77};
        tbl[16] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};

        Clr = 1'b1; EN = 1'b0; IMem_Ack = 1'b0; IMem_Data = '0; Redirect = 1'b0; Redirect_Targ = '0;
        for (int i = 0; i < 17; i++) begin
            Clr = tbl[i].clr; EN = tbl[i].en; IMem_Ack = tbl[i].ack; IMem_Data = tbl[i].data;
            Redirect = tbl[i].redir; Redirect_Targ = tbl[i].targ;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                    tbl[i].e_pc, tbl[i].e_inst);
        end

        // Zero-wait stream with EN=1: one instruction per cycle, Req never drops.
        do_reset();
        EN = 1'b1;
        zw_tick();
        chk("stream.startreq", {31'b0, IMem_Req}, 32'h1);
        for (int n = 2; n < 10; n++) begin
            zw_tick();
            chk_all($sformatf("stream%0d", n), 1'b1, 32'h4 * (n - 1), 1'b1, 32'h4 * (n - 2), 32'h4 * (n - 2));
        end

        // Fill with EN=0, then drain in order.
        do_reset();
        EN = 1'b0;
        for (int i = 0; i < 10; i++) zw_tick();
        IMem_Ack = 1'b0;
        chk("full.req", {31'b0, IMem_Req}, 32'h0);
        chk("full.valid", {31'b0, IFout_Valid}, 32'h1);
        chk("full.head", IFout_PC, 32'h0);
        EN = 1'b1;
        tick();
        chk_all("drain1", 1'b1, 32'h10, 1'b1, 32'h4, 32'h4);
        tick();
        chk_all("drain2", 1'b1, 32'h10, 1'b1, 32'h8, 32'h8);
        tick();
        chk_all("drain3", 1'b1, 32'h10, 1'b1, 32'hC, 32'hC);
        tick();
        chk_all("drain4", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);

        // Latency-3 memory with EN=1; redirect to 0x100 while 0x8 is pending.
        do_reset();
        EN = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            IMem_Ack = 1'b0;
            tick();
            chk_all($sformatf("lat3_%0da", k), 1'b1, 32'h4 * k, 1'b0, 32'h0, 32'h0);
            tick();
            chk_all($sformatf("lat3_%0db", k), 1'b1, 32'h4 * k, 1'b0, 32'h0, 32'h0);
            IMem_Ack = 1'b1; IMem_Data = 32'h4 * k;
            tick();
            chk_all($sformatf("lat3_%0dc", k), 1'b1, 32'h4 * (k + 1), 1'b1, 32'h4 * k, 32'h4 * k);
        end
        IMem_Ack = 1'b0; Redirect = 1'b1; Redirect_Targ = 32'h100;
        tick();
        Redirect = 1'b0;
        chk_all("rdr.hold1", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
        tick();
        chk_all("rdr.hold2", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
        IMem_Ack = 1'b1; IMem_Data = 32'hBAD0_0008;
        tick();
        chk_all("rdr.drop", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        IMem_Ack = 1'b0;
        tick();
        tick();
        chk_all("rdr.wait", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        IMem_Ack = 1'b1; IMem_Data = 32'h100;
        tick();
        chk_all("rdr.first", 1'b1, 32'h104, 1'b1, 32'h100, 32'h100);

        // Clr with three entries and a pending request; a late Ack must be ignored.
        do_reset();
        EN = 1'b0;
        for (int i = 0; i < 4; i++) zw_tick();
        chk("clr.pre", IFout_PC, 32'h0);
        IMem_Ack = 1'b0; Clr = 1'b1;
        tick();
        chk_all("clr.reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        Clr = 1'b0; IMem_Ack = 1'b1; IMem_Data = 32'hBAD0_BAD0;
        tick();
        chk_all("clr.lateack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        IMem_Ack = 1'b0;
        tick();
        chk_all("clr.after", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
